// File: rtl/uart_mem_loader.sv
// UART-driven loader for BRAM port B: receives 8N1 bytes, parses an A5/count/data
// frame and writes consecutive 16-bit words starting at BASE_ADDR.
module uart_mem_loader #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [WIDTH-1:0]      data_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  we_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TICK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0]     TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BYTE_W-1:0]     HDR_BYTE  = 8'hA5;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        LD_WAIT_HDR,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    // rx synchronizer plus one extra stage for falling-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_e          rx_state_q, rx_state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]  shreg_q, shreg_d;
    logic               byte_valid_q, byte_valid_d;
    logic               frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // UART receiver: mid-bit sampling, start-bit glitch rejection
    always_comb begin
        rx_state_d   = rx_state_q;
        tick_d       = tick_q + TICK_W'(1);
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                tick_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d    = '0;
                    shreg_d   = {rx_sync_q, shreg_q[BYTE_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d       = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    ld_state_e             ld_state_q, ld_state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BYTE_W-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      count_full;

    assign count_full = {cnt_q[CNT_W-1:BYTE_W], shreg_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_q <= LD_WAIT_HDR;
            ptr_q      <= BASE;
            cnt_q      <= '0;
            hi_q       <= '0;
            data_q     <= '0;
            addr_q     <= BASE;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Loader: outputs are set on the transition so we_b/done are high in WRITE/DONE
    always_comb begin
        ld_state_d = ld_state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        data_d     = data_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        if (frame_err_q) begin
            err_d = 1'b1;
            if (ld_state_q != LD_WAIT_HDR) begin
                ld_state_d = LD_WAIT_HDR;
                busy_d     = 1'b0;
            end
        end else begin
            case (ld_state_q)
                LD_WAIT_HDR: begin
                    if (byte_valid_q && shreg_q == HDR_BYTE) begin
                        err_d      = 1'b0;
                        busy_d     = 1'b1;
                        ptr_d      = BASE;
                        ld_state_d = LD_CNT_HI;
                    end
                end
                LD_CNT_HI: begin
                    if (byte_valid_q) begin
                        cnt_d      = {shreg_q, cnt_q[BYTE_W-1:0]};
                        ld_state_d = LD_CNT_LO;
                    end
                end
                LD_CNT_LO: begin
                    if (byte_valid_q) begin
                        cnt_d = count_full;
                        if (count_full == '0) begin
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            ld_state_d = LD_DONE;
                        end else begin
                            ld_state_d = LD_DATA_HI;
                        end
                    end
                end
                LD_DATA_HI: begin
                    if (byte_valid_q) begin
                        hi_d       = shreg_q;
                        ld_state_d = LD_DATA_LO;
                    end
                end
                LD_DATA_LO: begin
                    if (byte_valid_q) begin
                        we_d       = 1'b1;
                        data_d     = WIDTH'({hi_q, shreg_q});
                        addr_d     = ptr_q;
                        ld_state_d = LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        ld_state_d = LD_DONE;
                    end else begin
                        ld_state_d = LD_DATA_HI;
                    end
                end
                LD_DONE: ld_state_d = LD_WAIT_HDR;
                default: ld_state_d = LD_WAIT_HDR;
            endcase
        end
    end

    assign data_b = data_q;
    assign addr_b = addr_q;
    assign we_b   = we_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: table of framed loads plus hand-written
// glitch, address-wrap and mid-load reset sequences.
module tb_uart_mem_loader;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx0, rx1;
    logic [15:0] data0, addr0, data1, addr1;
    logic        we0, busy0, done0, err0;
    logic        we1, busy1, done1, err1;

    uart_mem_loader #(.WIDTH(16), .ADDR_WIDTH(16), .CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0010)) dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .data_b(data0), .addr_b(addr0),
        .we_b(we0), .busy(busy0), .done(done0), .err(err0)
    );

    uart_mem_loader #(.WIDTH(16), .ADDR_WIDTH(16), .CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF)) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .data_b(data1), .addr_b(addr1),
        .we_b(we1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // write/done logs gathered away from the active edge
    logic [15:0] wa0[$], wd0[$], wa1[$], wd1[$];
    int ndone0, ndone1, last_we0, done_cyc0, we_nobusy0;

    always @(negedge clk) begin
        if (we0) begin
            wa0.push_back(addr0);
            wd0.push_back(data0);
            last_we0 = cyc;
            if (!busy0) we_nobusy0++;
        end
        if (done0) begin
            ndone0++;
            done_cyc0 = cyc;
        end
        if (we1) begin
            wa1.push_back(addr1);
            wd1.push_back(data1);
        end
        if (done1) ndone1++;
    end

    typedef struct {
        int          nb;
        logic [7:0]  b [8];
        int          bad_idx;
        int          nwr;
        logic [15:0] wa [3];
        logic [15:0] wd [3];
        int          ndone;
        logic        err;
    } vec_t;

    vec_t vec [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        ndone0 = 0; ndone1 = 0; we_nobusy0 = 0;
        last_we0 = 0; done_cyc0 = 0;
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic send_frame(input int line, input logic [7:0] val, input logic stop);
        drive(line, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(line, val[i]);
            repeat (CPB) @(negedge clk);
        end
        drive(line, stop);
        repeat (CPB) @(negedge clk);
        drive(line, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " data_b"}, 32'(data0), 32'h0);
        check({tag, " addr_b"}, 32'(addr0), 32'h0010);
        check({tag, " we_b"},   32'(we0),   32'h0);
        check({tag, " busy"},   32'(busy0), 32'h0);
        check({tag, " done"},   32'(done0), 32'h0);
        check({tag, " err"},    32'(err0),  32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec[0].nb = 7; vec[0].b = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        vec[0].bad_idx = -1; vec[0].nwr = 2; vec[0].ndone = 1; vec[0].err = 1'b0;
        vec[0].wa = '{16'h0010, 16'h0011, 16'h0000}; vec[0].wd = '{16'h1234, 16'hABCD, 16'h0000};

        vec[1].nb = 3; vec[1].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[1].bad_idx = -1; vec[1].nwr = 0; vec[1].ndone = 1; vec[1].err = 1'b0;
        vec[1].wa = '{16'h0, 16'h0, 16'h0}; vec[1].wd = '{16'h0, 16'h0, 16'h0};

        vec[2].nb = 6; vec[2].b = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h56, 8'h00, 8'h00};
        vec[2].bad_idx = 5; vec[2].nwr = 1; vec[2].ndone = 0; vec[2].err = 1'b1;
        vec[2].wa = '{16'h0010, 16'h0, 16'h0}; vec[2].wd = '{16'h1122, 16'h0, 16'h0};

        vec[3].nb = 5; vec[3].b = '{8'hA5, 8'h00, 8'h01, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
        vec[3].bad_idx = -1; vec[3].nwr = 1; vec[3].ndone = 1; vec[3].err = 1'b0;
        vec[3].wa = '{16'h0010, 16'h0, 16'h0}; vec[3].wd = '{16'h3344, 16'h0, 16'h0};

        reset = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        clear_logs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("reset");
        check("reset dut1 addr_b", 32'(addr1), 32'h0000FFFF);

        for (int v = 0; v < 4; v++) begin
            clear_logs();
            for (int b = 0; b < vec[v].nb; b++)
                send_frame(0, vec[v].b[b], (b != vec[v].bad_idx));
            repeat (24) @(negedge clk);
            check($sformatf("v%0d write count", v), 32'(wa0.size()), 32'(vec[v].nwr));
            for (int w = 0; w < vec[v].nwr && w < wa0.size(); w++) begin
                check($sformatf("v%0d w%0d addr", v, w), 32'(wa0[w]), 32'(vec[v].wa[w]));
                check($sformatf("v%0d w%0d data", v, w), 32'(wd0[w]), 32'(vec[v].wd[w]));
            end
            check($sformatf("v%0d done count", v), 32'(ndone0), 32'(vec[v].ndone));
            check($sformatf("v%0d err", v), 32'(err0), 32'(vec[v].err));
            check($sformatf("v%0d busy", v), 32'(busy0), 32'h0);
            check($sformatf("v%0d we without busy", v), 32'(we_nobusy0), 32'h0);
            if (vec[v].nwr > 0) begin
                check($sformatf("v%0d addr_b held", v), 32'(addr0), 32'(vec[v].wa[vec[v].nwr-1]));
                check($sformatf("v%0d data_b held", v), 32'(data0), 32'(vec[v].wd[vec[v].nwr-1]));
            end
            if (vec[v].nwr > 0 && vec[v].ndone > 0)
                check($sformatf("v%0d done after last write", v), 32'(done_cyc0 - last_we0), 32'h1);
        end

        // junk bytes and a one-cycle start glitch must be ignored
        clear_logs();
        send_frame(0, 8'h55, 1'b1);
        send_frame(0, 8'hFF, 1'b1);
        rx0 = 1'b0;
        @(negedge clk);
        rx0 = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch err", 32'(err0), 32'h0);
        check("glitch busy", 32'(busy0), 32'h0);
        send_frame(0, 8'hA5, 1'b1);
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'h01, 1'b1);
        send_frame(0, 8'hBE, 1'b1);
        send_frame(0, 8'hEF, 1'b1);
        repeat (24) @(negedge clk);
        check("glitch write count", 32'(wa0.size()), 32'h1);
        if (wa0.size() > 0) begin
            check("glitch addr", 32'(wa0[0]), 32'h0010);
            check("glitch data", 32'(wd0[0]), 32'hBEEF);
        end
        check("glitch done count", 32'(ndone0), 32'h1);
        check("glitch err after", 32'(err0), 32'h0);

        // address pointer wraps from 0xFFFF to 0x0000
        clear_logs();
        send_frame(1, 8'hA5, 1'b1);
        send_frame(1, 8'h00, 1'b1);
        send_frame(1, 8'h02, 1'b1);
        send_frame(1, 8'h00, 1'b1);
        send_frame(1, 8'h01, 1'b1);
        send_frame(1, 8'h00, 1'b1);
        send_frame(1, 8'h02, 1'b1);
        repeat (24) @(negedge clk);
        check("wrap write count", 32'(wa1.size()), 32'h2);
        if (wa1.size() > 1) begin
            check("wrap w0 addr", 32'(wa1[0]), 32'h0000FFFF);
            check("wrap w0 data", 32'(wd1[0]), 32'h0001);
            check("wrap w1 addr", 32'(wa1[1]), 32'h0000);
            check("wrap w1 data", 32'(wd1[1]), 32'h0002);
        end
        check("wrap done count", 32'(ndone1), 32'h1);
        check("wrap dut0 untouched", 32'(wa0.size()), 32'h0);

        // reset during the second data byte of a 3-word load
        clear_logs();
        send_frame(0, 8'hA5, 1'b1);
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'h03, 1'b1);
        send_frame(0, 8'h11, 1'b1);
        rx0 = 1'b0;
        repeat (CPB) @(negedge clk);
        rx0 = 1'b0;
        repeat (CPB) @(negedge clk);
        rx0 = 1'b1;
        repeat (CPB) @(negedge clk);
        rx0 = 1'b0;
        repeat (2) @(negedge clk);
        check("midload busy", 32'(busy0), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx0 = 1'b1;
        check_reset_vals("midreset");
        clear_logs();
        repeat (60) @(negedge clk);
        check("midreset no write", 32'(wa0.size()), 32'h0);
        check("midreset no done", 32'(ndone0), 32'h0);
        send_frame(0, 8'hA5, 1'b1);
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'h01, 1'b1);
        send_frame(0, 8'h77, 1'b1);
        send_frame(0, 8'h88, 1'b1);
        repeat (24) @(negedge clk);
        check("post-reset write count", 32'(wa0.size()), 32'h1);
        if (wa0.size() > 0) begin
            check("post-reset addr", 32'(wa0[0]), 32'h0010);
            check("post-reset data", 32'(wd0[0]), 32'h7788);
        end
        check("post-reset done count", 32'(ndone0), 32'h1);
        check("post-reset err", 32'(err0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Serial program/data loader that drives the otherwise-idle port B of the dual-port BRAM (data_b, addr_b, we_b), upstream of the memory and the port-B memory-mapped I/O decode.
- Receives 8N1 UART bytes, parses a framed load command, and writes 16-bit words to consecutive BRAM addresses.
- busy can hold the CPU in reset while a load is in progress.

Parameters:
- WIDTH, 16, data word width. Must be 16: two bytes per word.
- ADDR_WIDTH, 16, width of addr_b.
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Must be >= 4.
- BASE_ADDR, 0, first BRAM address written by each load.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- rx  in  1  asynchronous UART line; idles high.
- data_b  out  WIDTH  word to BRAM port B.
- addr_b  out  ADDR_WIDTH  BRAM port B address.
- we_b  out  1  BRAM port B write enable; one-cycle pulse.
- busy  out  1  high from header accept until load complete or abort.
- done  out  1  one-cycle pulse after the last word is written.
- err  out  1  sticky framing/protocol error flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values: data_b=0, addr_b=BASE_ADDR, we_b=0, busy=0, done=0, err=0. All FSMs go to IDLE / WAIT_HDR. The synchronizer flops reset to 1.
- Reset mid-frame: abort immediately. No further we_b is issued. Words already written stay in memory.
- rx passes through a 2-flop synchronizer before any use.

UART receiver:
- States: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized 1->0 transition.
- START: at CLKS_PER_BIT/2 cycles, resample rx.
  - If rx is high, treat it as a glitch: return to IDLE, no error.
  - Otherwise go to DATA.
- DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles at mid-bit.
- STOP: sample mid-bit.
  - If 1: emit an internal byte_valid pulse for 1 cycle.
  - If 0: framing error. Discard the byte and set err.
  - Either way return to IDLE.

Loader FSM:
- States: WAIT_HDR, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE.
- WAIT_HDR: bytes other than 0xA5 are ignored. On 0xA5: clear err, set busy, set addr pointer to BASE_ADDR, go to CNT_HI.
- CNT_HI / CNT_LO: latch a 16-bit word count N, big-endian.
  - If N=0, go to DONE directly.
  - Otherwise go to DATA_HI.
- DATA_HI: latch the high byte.
- DATA_LO: latch the low byte, go to WRITE on the cycle after byte_valid.
- WRITE (one cycle):
  - we_b=1; data_b = {hi,lo}; addr_b = current pointer. These are stable for that cycle.
  - Next cycle: pointer increments mod 2^ADDR_WIDTH (0xFFFF wraps to 0x0000) and the remaining count decrements.
  - If remaining count becomes 0, go to DONE; otherwise go to DATA_HI.
- DONE: done=1 for exactly one cycle, busy=0, then WAIT_HDR.
- Framing error while busy: abort to WAIT_HDR, busy=0, no done. err stays 1 until the next accepted 0xA5 header or reset.
- Write latency: we_b asserts exactly 1 cycle after the byte_valid of the low byte.
- addr_b and data_b hold their last values when we_b=0.

Test Plan:
- CLKS_PER_BIT=4, BASE_ADDR=0x0010. Send A5 00 02 12 34 AB CD -> we_b pulses twice: (0x0010, 0x1234), then (0x0011, 0xABCD). done pulses once after the second write; busy is high between header and done.
- Send A5 00 00 -> no we_b. done pulses 1 cycle after the count low byte; busy ends at 0.
- Send 0x55 0xFF, then a 1-cycle low glitch on rx, then A5 00 01 BE EF -> the junk bytes and glitch are ignored, err=0. Exactly one write (BASE_ADDR, 0xBEEF).
- Send A5 00 03 11 22, then a byte with stop bit 0 -> err=1, busy=0, no further writes, no done. A following valid A5 00 01 33 44 clears err and writes (0x0010, 0x3344).
- BASE_ADDR=0xFFFF. Send A5 00 02 00 01 00 02 -> writes (0xFFFF, 0x0001), then (0x0000, 0x0002).
- Assert reset for 1 cycle during the second data byte of a 3-word load -> all outputs return to reset values, no further we_b. A subsequent complete frame loads correctly from BASE_ADDR.
